p_stack: RTL and testbench



---
 rtl/p_stack.sv | 74 +++++++
 tb/tb_p_stack.sv | 135 +++++++++++++
 2 files changed

// File: rtl/p_stack.sv
// p_stack: predicate (active-mask) stack for SIMT divergence.
// Entry 0 is the all-ones base mask. The top entry is the live mask q.
// push narrows the mask, comp switches to the else path, and pop reconverges.
// Each command runs once on the rising edge of its strobe.
module p_stack #(
  parameter int N_CORES = 4,
  parameter int DEPTH   = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N_CORES-1:0] d,
  output logic [N_CORES-1:0] q,
  input  logic               push,
  input  logic               pop,
  input  logic               comp,
  output logic               all_true,
  output logic               all_false
);

  localparam int SPW = (DEPTH < 1) ? 1 : $clog2(DEPTH + 1);
  localparam logic [SPW-1:0] SP_MAX = SPW'(DEPTH);
  localparam logic [SPW-1:0] SP_ONE = SPW'(1);

  logic [DEPTH:0][N_CORES-1:0] stk_q, stk_d;
  logic [SPW-1:0]              sp_q, sp_d;
  logic                        push_prev_q, pop_prev_q, comp_prev_q;
  logic                        push_e, pop_e, comp_e;

  // The stack pointer always stays in the range 0..DEPTH, so every index below is valid.
  assign q         = stk_q[sp_q];
  assign all_true  = &q;
  assign all_false = ~|q;

  assign push_e = push & ~push_prev_q;
  assign pop_e  = pop  & ~pop_prev_q;
  assign comp_e = comp & ~comp_prev_q;

  // Next state. Priority is push > pop > comp, and lower-priority edges are dropped.
  always_comb begin
    stk_d = stk_q;
    sp_d  = sp_q;
    if (push_e) begin
      if (sp_q != SP_MAX) begin
        sp_d        = sp_q + SP_ONE;
        stk_d[sp_d] = d & q;
      end
    end else if (pop_e) begin
      if (sp_q != '0) sp_d = sp_q - SP_ONE;
    end else if (comp_e) begin
      // The else path gets the parent lanes that the branch did not take.
      if (sp_q != '0) stk_d[sp_q] = ~stk_q[sp_q] & stk_q[sp_q - SP_ONE];
    end
    stk_d[0] = '1;
  end

  // Stack state, plus strobe history for edge detection.
  // Every history register updates, including for dropped commands.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stk_q       <= '1;
      sp_q        <= '0;
      push_prev_q <= 1'b0;
      pop_prev_q  <= 1'b0;
      comp_prev_q <= 1'b0;
    end else begin
      stk_q       <= stk_d;
      sp_q        <= sp_d;
      push_prev_q <= push;
      pop_prev_q  <= pop;
      comp_prev_q <= comp;
    end
  end

endmodule

// File: tb/tb_p_stack.sv
// Directed bench for p_stack. Expected masks are queued as each command is driven.
// They are popped and compared one time unit after the clock edge.
module tb_p_stack;
  localparam int N = 4;
  localparam int DEPTH = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic [N-1:0] d;
  logic [N-1:0] q;
  logic         push, pop, comp;
  logic         all_true, all_false;

  int checks = 0;
  int errors = 0;
  logic [N-1:0] sb [$];

  p_stack #(.N_CORES(N), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .d(d), .q(q),
    .push(push), .pop(pop), .comp(comp),
    .all_true(all_true), .all_false(all_false)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag);
    logic [N-1:0] e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s observed=empty-scoreboard expected=entry", tag);
    end else begin
      e = sb.pop_front();
      chk({tag, ".q"}, q, e);
      chk({tag, ".all_true"}, {{(N-1){1'b0}}, all_true}, {{(N-1){1'b0}}, (e == {N{1'b1}})});
      chk({tag, ".all_false"}, {{(N-1){1'b0}}, all_false}, {{(N-1){1'b0}}, (e == '0)});
    end
  endtask

  // Raise the strobes, check after the edge, then drop them so the next command sees a fresh edge.
  task automatic cmd(input string tag, input logic pu, input logic po, input logic co,
                     input logic [N-1:0] dv, input logic [N-1:0] exp);
    @(negedge clk);
    d = dv; push = pu; pop = po; comp = co;
    sb.push_back(exp);
    @(posedge clk);
    #1;
    chk_out(tag);
    @(negedge clk);
    push = 1'b0; pop = 1'b0; comp = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; d = '0; push = 1'b0; pop = 1'b0; comp = 1'b0;
    #12;
    sb.push_back(4'b1111);
    chk_out("reset_active");
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    sb.push_back(4'b1111);
    chk_out("reset_released");

    // Nested pushes
    cmd("push1", 1, 0, 0, 4'b1010, 4'b1010);
    cmd("push2", 1, 0, 0, 4'b0011, 4'b0010);
    cmd("push3", 1, 0, 0, 4'b0111, 4'b0010);
    cmd("push4", 1, 0, 0, 4'b0000, 4'b0000);
    // Else path
    cmd("comp1", 0, 0, 1, 4'b0000, 4'b0010);
    cmd("comp2", 0, 0, 1, 4'b0000, 4'b0000);
    // Reconverge
    cmd("pop1", 0, 1, 0, 4'b0000, 4'b0010);
    cmd("pop2", 0, 1, 0, 4'b0000, 4'b0010);
    cmd("pop3", 0, 1, 0, 4'b0000, 4'b1010);
    cmd("pop4", 0, 1, 0, 4'b0000, 4'b1111);
    cmd("pop_empty", 0, 1, 0, 4'b0000, 4'b1111);
    cmd("comp_sp0", 0, 0, 1, 4'b0000, 4'b1111);

    // Overflow: the ninth push and a later push of 0000 are both ignored.
    for (int i = 0; i <= DEPTH; i++) cmd("push_fill", 1, 0, 0, 4'b1111, 4'b1111);
    cmd("push_full_ignored", 1, 0, 0, 4'b0000, 4'b1111);
    cmd("comp_at_full", 0, 0, 1, 4'b0000, 4'b0000);
    for (int i = 0; i < DEPTH; i++) cmd("pop_drain", 0, 1, 0, 4'b0000, 4'b1111);
    cmd("push_after_drain", 1, 0, 0, 4'b0101, 4'b0101);
    cmd("pop_after_drain", 0, 1, 0, 4'b0000, 4'b1111);

    // A push held high for five cycles executes only once.
    @(negedge clk);
    d = 4'b1100; push = 1'b1;
    for (int i = 0; i < 5; i++) begin
      sb.push_back(4'b1100);
      @(posedge clk); #1;
      chk_out("push_held");
    end
    @(negedge clk);
    push = 1'b0;
    cmd("pop_after_held", 0, 1, 0, 4'b0000, 4'b1111);

    // When push and pop arrive together, only the push executes.
    cmd("push_pop_same", 1, 1, 0, 4'b1001, 4'b1001);
    cmd("pop_after_same", 0, 1, 0, 4'b0000, 4'b1111);

    // Async reset asserted mid-cycle at sp=3
    cmd("pre_rst1", 1, 0, 0, 4'b1110, 4'b1110);
    cmd("pre_rst2", 1, 0, 0, 4'b0110, 4'b0110);
    cmd("pre_rst3", 1, 0, 0, 4'b0100, 4'b0100);
    @(posedge clk); #2;
    reset = 1'b0;
    #1;
    sb.push_back(4'b1111);
    chk_out("async_reset");
    @(negedge clk);
    reset = 1'b1;
    cmd("post_rst_push", 1, 0, 0, 4'b0001, 4'b0001);
    cmd("post_rst_pop", 0, 1, 0, 4'b0000, 4'b1111);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
